// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic [3:0]       id_alu_op,
  input  logic             flush,
  input  logic             ex_busy,
  output logic             stall_if,
  output logic             ID_EX_valid,
  output logic [4:0]       ID_EX_rs1,
  output logic [4:0]       ID_EX_rs2,
  output logic [4:0]       ID_EX_rd,
  output logic [XLEN-1:0]  ID_EX_rs1_data,
  output logic [XLEN-1:0]  ID_EX_rs2_data,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic             ID_EX_reg_write,
  output logic             ID_EX_mem_read,
  output logic             ID_EX_mem_write,
  output logic             ID_EX_mem_to_reg,
  output logic             ID_EX_alu_src,
  output logic             ID_EX_branch,
  output logic [3:0]       ID_EX_alu_op,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [1:0] ACT_LOAD   = 2'd0;
  localparam logic [1:0] ACT_HOLD   = 2'd1;
  localparam logic [1:0] ACT_BUBBLE = 2'd2;
  localparam logic [1:0] ACT_FLUSH  = 2'd3;

  localparam int SW = 1 + 15 + 4*XLEN + 6 + 4;

  logic [SW-1:0]    stage_q, stage_d, capture;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       act;
  logic             load_use;
  logic [5:0]       ctrl_in;

  // Stage register layout, MSB first: valid, rs1, rs2, rd, rs1_data, rs2_data,
  // imm, pc, {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch}, alu_op.
  assign {ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_rs1_data,
          ID_EX_rs2_data, ID_EX_imm, ID_EX_pc, ID_EX_reg_write, ID_EX_mem_read,
          ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_branch,
          ID_EX_alu_op} = stage_q;

  assign load_use = ID_EX_valid & ID_EX_mem_read & (ID_EX_rd != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ID_EX_rd)) |
                     (id_uses_rs2 & (id_rs2 == ID_EX_rd)));

  assign stall_if = ~flush & (ex_busy | load_use);

  always_comb begin
    if (flush)         act = ACT_FLUSH;
    else if (ex_busy)  act = ACT_HOLD;
    else if (load_use) act = ACT_BUBBLE;
    else               act = ACT_LOAD;
  end

  // An empty decode slot still captures its fields, but must never write or access memory.
  assign ctrl_in = id_valid ? {id_reg_write, id_mem_read, id_mem_write,
                               id_mem_to_reg, id_alu_src, id_branch} : 6'd0;

  assign capture = {id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
                    id_imm, id_pc, ctrl_in, id_alu_op};

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (act)
      ACT_FLUSH:  stage_d = '0;
      ACT_HOLD:   stage_d = stage_q;
      ACT_BUBBLE: begin
        stage_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default:    stage_d = capture;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bubble_count = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection. It sits between decode and execute. It captures decoded operands and control, and drives the ID_EX_* fields that the forwarding unit compares against EX/MEM and MEM/WB destinations. It also generates the upstream stall for load-use hazards, honours branch flushes and execute-busy holds, and counts bubble cycles for performance monitoring.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of bubble counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2, id_rd  in  5 each  decoded register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1/rs2
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  operands, immediate, PC
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  control
- id_alu_op  in  4  ALU operation
- flush  in  1  branch mispredict from EX; kill decode slot
- ex_busy  in  1  EX holding its instruction (multi-cycle op)
- stall_if  out  1  hold PC and IF/ID this cycle (combinational)
- ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_branch, ID_EX_alu_op  out  widths as inputs  registered stage contents
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- load_use = ID_EX_valid & ID_EX_mem_read & (ID_EX_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ID_EX_rd) | (id_uses_rs2 & id_rs2 == ID_EX_rd)).
- The next-state action is selected in strict priority order:
  - FLUSH (flush=1): load a bubble.
  - HOLD (ex_busy=1): all registers keep their values.
  - BUBBLE (load_use=1): load a bubble.
  - LOAD (otherwise): capture all id_* fields. ID_EX_valid takes id_valid.
- A bubble sets ID_EX_valid and all control bits (reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch) to 0. It sets ID_EX_alu_op, rs1, rs2 and rd to 0 and zeroes all data fields. A bubble therefore can never match in the forwarding unit, because rd=0 and reg_write=0.
- If id_valid=0 and LOAD is selected, the register captures id_* fields as presented, but all control bits are forced to 0.
- stall_if = ~flush & (ex_busy | load_use). During a flush, upstream is redirected, so no stall is asserted.
- bubble_count increments by 1 on every edge where BUBBLE is selected. It does not count FLUSH or HOLD. It saturates at 2^CNT_W−1 and never wraps.
- The block has no internal FSM beyond the priority select. It is stateless apart from the stage register and the counter.

## Timing
- Reset (rst_n=0, asynchronous): every ID_EX_* output is 0, bubble_count is 0, and the stage holds a bubble. stall_if then evaluates to ex_busy only, because load_use is 0 when ID_EX_valid=0.
- Reset release takes effect at the first rising edge with rst_n=1.
- Latency: an id_* value presented in cycle N appears on ID_EX_* after the edge ending cycle N, provided the action is LOAD.
- Load-use costs exactly one bubble cycle:
  - Cycle N: load in ID/EX, dependent instruction in decode. stall_if=1.
  - Edge: a bubble is inserted while decode holds.
  - Cycle N+1: load_use=0 and the dependent instruction loads.
- HOLD with load_use=1: the stage holds, stall_if=1, and bubble_count does not increment.
- Flush concurrent with load_use or ex_busy: flush wins. A bubble is loaded, stall_if=0 and bubble_count is unchanged.
- A load whose rd=0 never stalls. A load followed by an instruction with uses_rs*=0 on the matching index never stalls.
- Reset asserted mid-hold: outputs clear immediately. No stall persists past reset apart from stall_if following ex_busy combinationally.

## Test plan
- Reset: assert rst_n=0 mid-stream with valid ID_EX contents -> all ID_EX_* and bubble_count read 0 asynchronously (before the next edge); the stage holds a bubble, stall_if=0 with ex_busy=0 and follows ex_busy.
- Load-use: present lw x5 (rd=5, mem_read=1), then add x6,x5,x1 -> stall_if=1 for exactly one cycle; one bubble appears (valid=0, rd=0); the add appears in ID/EX the following cycle; bubble_count goes 0→1.
- No false stall: lw x0, then add using x0 -> no stall. lw x5, then an instruction with id_uses_rs2=0 and id_rs2=5 -> no stall.
- Priority: assert flush, ex_busy and load_use in the same cycle -> a bubble is loaded, stall_if=0, bubble_count unchanged. Then ex_busy=1 with load_use=1 -> contents held for 3 cycles, stall_if=1, count unchanged.
- Saturation: with CNT_W=4, force 20 load-use bubbles -> bubble_count stops at 15.
- Back-to-back LOAD: stream 8 independent instructions with distinct rd and imm -> each appears on ID_EX_* one cycle after presentation with all fields intact.
